// File: rtl/uart_rx_if.sv
// Serial receive bundle between the UART line and the peripheral register block.
// master is the receiver side; slave is the line driver / byte consumer side.
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        input  rx,
        output rx_data,
        output rx_valid,
        output frame_err,
        output rx_busy
    );

    modport slave (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, start-glitch rejection,
// stop-bit check and break hold-off.
module uart_rx #(
    parameter int CLKS_PER_BIT = 10416
) (
    input logic      UART_CLK,
    input logic      reset,
    uart_rx_if.master bus
);
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t      state, state_d;
    logic        rx_meta, rx_s;
    logic [15:0] clk_cnt, cnt_d;
    logic [2:0]  bit_idx, idx_d;
    logic [7:0]  shift_reg, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;

    always_ff @(posedge UART_CLK or negedge reset) begin
        if (!reset) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta   <= bus.rx;
            rx_s      <= rx_meta;
            state     <= state_d;
            clk_cnt   <= cnt_d;
            bit_idx   <= idx_d;
            shift_reg <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = clk_cnt + 16'd1;
        idx_d   = bit_idx;
        shift_d = shift_reg;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (clk_cnt == HALF_M1) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt == FULL_M1) begin
                    cnt_d = '0;
                    shift_d[bit_idx] = rx_s;
                    idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (clk_cnt == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_reg;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                // hold here while the line stays low so a break is one error
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.rx_busy   = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx at 16 clocks per bit.
// Expected pulses are queued by the stimulus and popped by a monitor.
module tb_uart_rx;
    localparam int CPB = 16;
    localparam int LAT = 155;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         t_start;
        bit         gap_chk;
    } exp_t;

    logic UART_CLK = 1'b0;
    logic reset    = 1'b0;
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   last_pulse = 0;
    logic [7:0] last_good = 8'h00;
    exp_t q[$];

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .UART_CLK (UART_CLK),
        .reset    (reset),
        .bus      (bus.master)
    );

    always #5 UART_CLK = ~UART_CLK;
    always @(posedge UART_CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic chk_rng(input string name, input int act,
                           input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // monitor: every output pulse must match the head of the queue
    always @(negedge UART_CLK) begin
        if (reset && (bus.rx_valid || bus.frame_err)) begin
            exp_t e;
            chk("valid_err_excl", int'(bus.rx_valid && bus.frame_err), 0);
            if (q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                e = q.pop_front();
                chk("pulse_kind", int'(bus.frame_err), int'(e.is_err));
                chk("rx_data", int'(bus.rx_data), int'(e.data));
                chk_rng("latency", cyc - e.t_start, LAT - 1, LAT + 1);
                if (e.gap_chk)
                    chk_rng("b2b_spacing", cyc - last_pulse, 10 * CPB - 1, 10 * CPB + 1);
            end
            last_pulse = cyc;
        end
    end

    task automatic step();
        @(posedge UART_CLK);
        #1;
    endtask

    task automatic hold(input logic v, input int n);
        bus.rx = v;
        repeat (n) step();
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok, input bit gap);
        exp_t e;
        e.is_err  = !stop_ok;
        e.data    = stop_ok ? b : last_good;
        e.t_start = cyc;
        e.gap_chk = gap;
        q.push_back(e);
        if (stop_ok) last_good = b;
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop_ok, CPB);
    endtask

    task automatic outputs_idle(input string tag, input logic [7:0] d);
        @(negedge UART_CLK);
        chk({tag, "_busy"}, int'(bus.rx_busy), 0);
        chk({tag, "_valid"}, int'(bus.rx_valid), 0);
        chk({tag, "_ferr"}, int'(bus.frame_err), 0);
        chk({tag, "_data"}, int'(bus.rx_data), int'(d));
        step();
    endtask

    initial begin
        bus.rx = 1'b1;
        repeat (3) step();
        reset = 1'b1;
        hold(1'b1, 100);
        outputs_idle("reset", 8'h00);

        send(8'hA5, 1'b1, 1'b0);
        hold(1'b1, 20);

        // bad stop then a held-low line must give exactly one error
        send(8'h81, 1'b0, 1'b0);
        hold(1'b0, 40);
        hold(1'b1, 20);
        send(8'h42, 1'b1, 1'b0);
        hold(1'b1, 20);

        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b1);
        send(8'h3C, 1'b1, 1'b1);
        hold(1'b1, 20);

        hold(1'b0, 4);
        hold(1'b1, 10);
        @(negedge UART_CLK);
        chk("glitch_busy", int'(bus.rx_busy), 0);
        step();
        send(8'h55, 1'b1, 1'b0);
        hold(1'b1, 20);

        // reset in the middle of data bit 4
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(1'($urandom_range(0, 1)), CPB);
        hold(1'b0, CPB / 2);
        reset = 1'b0;
        bus.rx = 1'b1;
        last_good = 8'h00;
        repeat (3) step();
        outputs_idle("in_reset", 8'h00);
        reset = 1'b1;
        hold(1'b1, 200);
        outputs_idle("post_abort", 8'h00);
        send(8'h99, 1'b1, 1'b0);
        hold(1'b1, 20);

        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            bit ok;
            b  = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            send(b, ok, 1'b0);
            if (ok) begin
                hold(1'b1, $urandom_range(0, 12));
            end else begin
                hold(1'b0, $urandom_range(0, 30));
                hold(1'b1, $urandom_range(4, 12));
            end
        end

        hold(1'b1, 20);
        for (int i = 0; i < 400 && q.size() != 0; i++) step();
        chk("queue_drained", q.size(), 0);
        outputs_idle("final", last_good);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver, the receive-side counterpart of the processor's UART transmitter. It sits on the same UART_CLK domain and uses the same baud divisor.
- Oversamples the asynchronous serial line and rejects start-bit glitches.
- Samples each bit at mid-period and checks the stop bit.
- Presents received bytes to the UART peripheral register block with a one-cycle valid strobe.

Parameters:
CLKS_PER_BIT, 10416, UART_CLK cycles per bit period; matches the transmitter divisor; legal range 4..65535.

Ports:
UART_CLK  input  1  block clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
rx  input  1  serial line, asynchronous to UART_CLK, idle high
rx_data  output  8  last correctly framed byte; LSB received first
rx_valid  output  1  one-cycle pulse: rx_data updated this cycle
frame_err  output  1  one-cycle pulse: stop bit sampled low
rx_busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - rx_data=8'h00, rx_valid=0, frame_err=0, rx_busy=0.
  - State=IDLE, counters cleared.
  - Synchronizer flops preset to 1 (idle level).
  - Reset mid-frame aborts the frame silently: no valid or error pulse after release.
- Input path: rx passes through a 2-flop synchronizer. Only the synchronized bit (rx_s) is used.
- Counter: clk_cnt is 16-bit, cleared on every state entry, increments each cycle while in a timed state.
- States:
  - IDLE: rx_s==0 -> START.
  - START:
    - At clk_cnt==CLKS_PER_BIT/2-1 (integer divide), sample rx_s.
    - 0 -> DATA with bit_idx=0.
    - 1 -> IDLE (glitch rejected, no pulse).
  - DATA:
    - At clk_cnt==CLKS_PER_BIT-1, shift rx_s into shift_reg[bit_idx] and increment bit_idx.
    - After bit_idx 7 is sampled -> STOP.
  - STOP:
    - At clk_cnt==CLKS_PER_BIT-1, sample rx_s.
    - 1 -> rx_data<=shift_reg, rx_valid=1 for exactly one cycle -> IDLE.
    - 0 -> frame_err=1 for one cycle, rx_data unchanged -> BREAK.
  - BREAK: wait until rx_s==1, then -> IDLE. Prevents a held-low line (break) from producing repeated frames.
- Sample points: because of the half-period alignment in START, every data and stop sample falls at mid-bit ±1 cycle.
- Latency: rx_valid rises 9.5·CLKS_PER_BIT + 3 cycles (±1) after the rx falling edge of the start bit.
- Back-to-back frames: the next start bit may begin immediately after the stop-bit mid-point. IDLE is reached before the next falling edge arrives, so zero idle time between frames is supported.
- rx_valid and frame_err are never high in the same cycle.
- rx_data holds its value until the next good frame.
- No flow control: a byte the consumer misses in the rx_valid cycle is lost. Overrun detection belongs to the register block.
- Inputs are never X-propagated into state: rx_s is treated as 0/1 only.

Test Plan:
Run with CLKS_PER_BIT=16 unless stated.
- Release reset, drive rx=1 for 100 cycles -> rx_busy=0, rx_valid=0, frame_err=0, rx_data=8'h00.
- Send frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> single rx_valid pulse with rx_data=8'hA5, 155±1 cycles after the start edge; frame_err stays 0.
- Send 0x00, 0xFF, 0x3C back-to-back with no idle gap -> three rx_valid pulses carrying 8'h00, 8'hFF, 8'h3C in order, spaced 160±1 cycles.
- Drive rx low for 4 cycles, then high -> no pulse; rx_busy returns to 0 within 10 cycles; a following frame 0x55 is received correctly.
- Send 0x81 with stop bit 0, hold rx low for 40 cycles, then release, then send 0x42:
  - Exactly one frame_err pulse, no rx_valid, rx_data still 8'hA5 from the prior frame.
  - Then rx_valid with rx_data=8'h42.
- Assert reset=0 during DATA bit 4 of a frame, release, then send 0x99 -> no pulse from the aborted frame; outputs at reset values during reset; then rx_data=8'h99 with rx_valid.
